extbus_master_6502: RTL and testbench

Initiator end of the VERA 6502 slave bus. It generates a free-running PHY2 from intbus_clk and turns single-register command requests into 6502-timed bus cycles (CS#, R/W#, A[2:0], D[7:0]). Read data is returned on a response port. Used in the FPGA test harness and in the host-side bridge that drives a VERA slave bus interface.

---
 rtl/extbus_6502_pkg.sv | 18 +
 rtl/extbus_phy2_gen.sv | 49 ++++
 rtl/extbus_master_6502.sv | 152 +++++++++++++++
 tb/tb_extbus_master_6502.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/extbus_6502_pkg.sv
// Shared types and constants for the VERA 6502 slave-bus initiator.
package extbus_6502_pkg;

  localparam int HALF_PERIOD_DEFAULT = 4;
  localparam int CNT_W               = 8;

  localparam logic [2:0] REG_ADDR_HI  = 3'd0;
  localparam logic [2:0] REG_ADDR_MID = 3'd1;
  localparam logic [2:0] REG_ADDR_LO  = 3'd2;
  localparam logic [2:0] REG_DATA     = 3'd3;

  typedef struct packed {
    logic       write;
    logic [2:0] addr;
    logic [7:0] wrdata;
  } cmd_t;

endpackage

// File: rtl/extbus_phy2_gen.sv
// Free-running PHY2 generator. Each strobe is high during the clk cycle
// whose closing edge is the PHY2 rise, the PHY2 fall (t0), or t1.
module extbus_phy2_gen
  import extbus_6502_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
  input  logic intbus_clk,
  input  logic extbus_reset,
  output logic phy2,
  output logic rise,
  output logic fall,
  output logic t1
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phy2_q, phy2_d;
  logic             t1_q, t1_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(HALF_PERIOD - 1));
  assign rise = wrap & ~phy2_q;
  assign fall = wrap & phy2_q;
  assign t1   = t1_q;
  assign phy2 = phy2_q;

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    phy2_d = phy2_q;
    t1_d   = fall;
    if (wrap) begin
      cnt_d  = '0;
      phy2_d = ~phy2_q;
    end
  end

  always_ff @(posedge intbus_clk or posedge extbus_reset) begin
    if (extbus_reset) begin
      cnt_q  <= '0;
      phy2_q <= 1'b0;
      t1_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      phy2_q <= phy2_d;
      t1_q   <= t1_d;
    end
  end

endmodule

// File: rtl/extbus_master_6502.sv
// Initiator for the VERA 6502 slave bus: one-deep command slot, 6502-timed cycles.
// Optional EXTBUS_MASTER_RDY_EN: extbus_rdy low at t0 repeats the active cycle.
module extbus_master_6502
  import extbus_6502_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT
) (
  input  logic       intbus_clk,
  input  logic       extbus_reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wrdata,
  output logic       rsp_valid,
  output logic       rsp_write,
  output logic [7:0] rsp_rddata,
  output logic       extbus_phy2,
  output logic       extbus_cs_n,
  output logic       extbus_rw_n,
  output logic [2:0] extbus_a,
  output logic [7:0] extbus_d_out,
  output logic       extbus_d_oe,
  input  logic [7:0] extbus_d_in,
  input  logic       extbus_rdy,
  input  logic       extbus_irq_n,
  output logic       irq
);

  logic rise, fall, t1, rdy_ok;

  extbus_phy2_gen #(.HALF_PERIOD(HALF_PERIOD)) u_phy2 (
    .intbus_clk  (intbus_clk),
    .extbus_reset(extbus_reset),
    .phy2        (extbus_phy2),
    .rise        (rise),
    .fall        (fall),
    .t1          (t1)
  );

`ifdef EXTBUS_MASTER_RDY_EN
  assign rdy_ok = extbus_rdy;
`else
  logic rdy_unused;
  assign rdy_unused = extbus_rdy;
  assign rdy_ok     = 1'b1;
`endif

  logic       pending_q, pending_d, active_q, active_d;
  cmd_t       cmd_q, cmd_d, act_q, act_d;
  logic       cs_n_q, cs_n_d, rw_n_q, rw_n_d, d_oe_q, d_oe_d;
  logic [2:0] a_q, a_d;
  logic [7:0] d_out_q, d_out_d, rsp_rddata_q, rsp_rddata_d;
  logic       rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic       irq_meta_q, irq_q;

  // Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready;
  // cmd_ready is simply "the pending slot is empty" and never depends on cmd_valid.
  assign cmd_ready = ~pending_q;

  always_comb begin
    pending_d    = pending_q;
    active_d     = active_q;
    cmd_d        = cmd_q;
    act_d        = act_q;
    cs_n_d       = cs_n_q;
    rw_n_d       = rw_n_q;
    a_d          = a_q;
    d_out_d      = d_out_q;
    d_oe_d       = d_oe_q;
    rsp_valid_d  = 1'b0;
    rsp_write_d  = rsp_write_q;
    rsp_rddata_d = rsp_rddata_q;

    if (cmd_valid && !pending_q) begin
      pending_d = 1'b1;
      cmd_d     = '{write: cmd_write, addr: cmd_addr, wrdata: cmd_wrdata};
    end

    if (rise && active_q && act_q.write) begin
      d_oe_d  = 1'b1;
      d_out_d = act_q.wrdata;
    end

    // A cycle held off by RDY stays active, so the t1 branch below leaves the bus untouched.
    if (fall && active_q && rdy_ok) begin
      rsp_valid_d  = 1'b1;
      rsp_write_d  = act_q.write;
      rsp_rddata_d = act_q.write ? 8'h00 : extbus_d_in;
      active_d     = 1'b0;
    end

    if (t1 && !active_q) begin
      cs_n_d = 1'b1;
      rw_n_d = 1'b1;
      d_oe_d = 1'b0;
      if (pending_q) begin
        cs_n_d    = 1'b0;
        rw_n_d    = ~cmd_q.write;
        a_d       = cmd_q.addr;
        act_d     = cmd_q;
        active_d  = 1'b1;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge intbus_clk or posedge extbus_reset) begin
    if (extbus_reset) begin
      pending_q    <= 1'b0;
      active_q     <= 1'b0;
      cmd_q        <= '0;
      act_q        <= '0;
      cs_n_q       <= 1'b1;
      rw_n_q       <= 1'b1;
      a_q          <= 3'd0;
      d_out_q      <= 8'h00;
      d_oe_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      rsp_rddata_q <= 8'h00;
      irq_meta_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      active_q     <= active_d;
      cmd_q        <= cmd_d;
      act_q        <= act_d;
      cs_n_q       <= cs_n_d;
      rw_n_q       <= rw_n_d;
      a_q          <= a_d;
      d_out_q      <= d_out_d;
      d_oe_q       <= d_oe_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_write_q  <= rsp_write_d;
      rsp_rddata_q <= rsp_rddata_d;
      irq_meta_q   <= ~extbus_irq_n;
      irq_q        <= irq_meta_q;
    end
  end

  assign extbus_cs_n  = cs_n_q;
  assign extbus_rw_n  = rw_n_q;
  assign extbus_a     = a_q;
  assign extbus_d_out = d_out_q;
  assign extbus_d_oe  = d_oe_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_rddata   = rsp_rddata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_extbus_master_6502.sv
// Directed bench for extbus_master_6502 with HALF_PERIOD = 4 (PHY2 period 8 clks).
module tb_extbus_master_6502;
  import extbus_6502_pkg::*;

  logic       intbus_clk, extbus_reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wrdata;
  logic       rsp_valid, rsp_write;
  logic [7:0] rsp_rddata;
  logic       extbus_phy2, extbus_cs_n, extbus_rw_n, extbus_d_oe;
  logic [2:0] extbus_a;
  logic [7:0] extbus_d_out, extbus_d_in;
  logic       extbus_rdy, extbus_irq_n, irq;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc   = 0;
  logic [8:0] exp_q[$];
  int         rsp_cyc[$];

  localparam logic [26:0] RST_VEC = {1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0,
                                     1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

  typedef struct {
    logic       w;
    logic [2:0] addr;
    logic [7:0] wrdata;
    logic [7:0] d_in;
    logic       exp_rw_n;
    logic       exp_d_oe;
    logic [7:0] exp_rddata;
  } vec_t;

  vec_t vecs[4];

  extbus_master_6502 #(.HALF_PERIOD(4)) dut (
    .intbus_clk  (intbus_clk),
    .extbus_reset(extbus_reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wrdata  (cmd_wrdata),
    .rsp_valid   (rsp_valid),
    .rsp_write   (rsp_write),
    .rsp_rddata  (rsp_rddata),
    .extbus_phy2 (extbus_phy2),
    .extbus_cs_n (extbus_cs_n),
    .extbus_rw_n (extbus_rw_n),
    .extbus_a    (extbus_a),
    .extbus_d_out(extbus_d_out),
    .extbus_d_oe (extbus_d_oe),
    .extbus_d_in (extbus_d_in),
    .extbus_rdy  (extbus_rdy),
    .extbus_irq_n(extbus_irq_n),
    .irq         (irq)
  );

  // clock / reset
  initial begin
    intbus_clk = 1'b0;
    forever #5 intbus_clk = ~intbus_clk;
  end

  initial forever begin
    @(posedge intbus_clk);
    cyc++;
  end

  task automatic tick();
    @(posedge intbus_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] out_vec();
    return {extbus_phy2, extbus_cs_n, extbus_rw_n, extbus_a, extbus_d_out, extbus_d_oe,
            rsp_valid, rsp_write, rsp_rddata, irq, cmd_ready};
  endfunction

  // Returns once PHY2 has just reached lvl; cnt = clks waited.
  task automatic wait_edge(input logic lvl, output int cnt);
    logic prev;
    prev = extbus_phy2;
    for (int n = 1; n <= 64; n++) begin
      tick();
      if (extbus_phy2 === lvl && prev !== lvl) begin
        cnt = n;
        return;
      end
      prev = extbus_phy2;
    end
    cnt = -1;
    n_cmp++;
    n_err++;
    $display("FAIL phy2_timeout: no PHY2 edge to %0b within 64 clks", lvl);
  endtask

  // driver
  task automatic issue_cmd(input logic w, input logic [2:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      n_cmp++;
      n_err++;
      $display("FAIL cmd_ready_timeout: cmd_ready stayed %0b, want 1", cmd_ready);
    end
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_addr   = a;
    cmd_wrdata = d;
    tick();
    cmd_valid  = 1'b0;
    exp_q.push_back({w, w ? 8'h00 : exp_rd});
  endtask

  task automatic count_cs_low(output int run);
    int n;
    n = 0;
    while (extbus_cs_n !== 1'b0 && n < 64) begin
      tick();
      n++;
    end
    run = 0;
    while (extbus_cs_n === 1'b0 && run < 64) begin
      run++;
      tick();
    end
  endtask

  // scoreboard
  initial forever begin
    @(negedge intbus_clk);
    if (rsp_valid === 1'b1) begin
      rsp_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: rsp_valid=1 rddata=0x%0h, want no response", rsp_rddata);
      end else begin
        chk("rsp_write_rddata", {rsp_write, rsp_rddata}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int c, run, base;

    vecs[0] = '{1'b1, REG_ADDR_MID, 8'hA5, 8'hFF, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b0, REG_DATA,     8'h00, 8'h5C, 1'b1, 1'b0, 8'h5C};
    vecs[2] = '{1'b1, 3'd7,         8'h3C, 8'h81, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{1'b0, REG_ADDR_HI,  8'hFF, 8'hA3, 1'b1, 1'b0, 8'hA3};

    extbus_reset = 1'b1;
    cmd_valid    = 1'b0;
    cmd_write    = 1'b0;
    cmd_addr     = 3'd0;
    cmd_wrdata   = 8'h00;
    extbus_d_in  = 8'h00;
    extbus_rdy   = 1'b1;
    extbus_irq_n = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", out_vec(), RST_VEC);
    extbus_reset = 1'b0;

    // idle PHY2 timing
    wait_edge(1'b1, c);
    chk("first_rise_clks", c, 4);
    wait_edge(1'b0, c);
    chk("phy2_high_clks", c, 4);
    wait_edge(1'b1, c);
    chk("phy2_low_clks", c, 4);
    chk("idle_cs_n", extbus_cs_n, 1'b1);
    chk("idle_irq", irq, 1'b0);

    // irq synchroniser
    extbus_irq_n = 1'b0;
    tick();
    chk("irq_after_1clk", irq, 1'b0);
    tick();
    chk("irq_after_2clk", irq, 1'b1);
    extbus_irq_n = 1'b1;
    repeat (2) tick();
    chk("irq_release", irq, 1'b0);

    // single-cycle vectors
    for (int i = 0; i < 4; i++) begin
      wait_edge(1'b1, c);
      issue_cmd(vecs[i].w, vecs[i].addr, vecs[i].wrdata, vecs[i].exp_rddata);
      extbus_d_in = vecs[i].d_in;
      wait_edge(1'b0, c);
      chk($sformatf("v%0d_cs_before_t1", i), extbus_cs_n, 1'b1);
      tick();
      chk($sformatf("v%0d_issue_bus", i), {extbus_cs_n, extbus_rw_n, extbus_a, extbus_d_oe},
          {1'b0, vecs[i].exp_rw_n, vecs[i].addr, 1'b0});
      chk($sformatf("v%0d_ready_active", i), cmd_ready, 1'b1);
      wait_edge(1'b1, c);
      chk($sformatf("v%0d_d_oe", i), extbus_d_oe, vecs[i].exp_d_oe);
      if (vecs[i].w) chk($sformatf("v%0d_d_out", i), extbus_d_out, vecs[i].wrdata);
      wait_edge(1'b0, c);
      chk($sformatf("v%0d_hold_after_t0", i), {extbus_cs_n, extbus_rw_n, extbus_a, extbus_d_oe},
          {1'b0, vecs[i].exp_rw_n, vecs[i].addr, vecs[i].exp_d_oe});
      tick();
      chk($sformatf("v%0d_release", i), {extbus_cs_n, extbus_rw_n, extbus_d_oe}, 3'b110);
    end

    // command accepted on the t1 edge waits a full period
    wait_edge(1'b0, c);
    issue_cmd(1'b1, REG_ADDR_LO, 8'h5A, 8'h00);
    chk("t1_accept_not_issued", {extbus_cs_n, cmd_ready}, 2'b10);
    wait_edge(1'b0, c);
    tick();
    chk("t1_accept_issued", {extbus_cs_n, extbus_a}, {1'b0, REG_ADDR_LO});
    wait_edge(1'b0, c);
    tick();
    chk("t1_accept_done", extbus_cs_n, 1'b1);

    // back-to-back
    extbus_d_in = 8'h77;
    base = rsp_cyc.size();
    fork
      begin
        wait_edge(1'b1, c);
        issue_cmd(1'b1, REG_ADDR_HI, 8'h10, 8'h00);
        issue_cmd(1'b1, REG_ADDR_MID, 8'h00, 8'h00);
        issue_cmd(1'b0, REG_DATA, 8'h00, 8'h77);
      end
      count_cs_low(run);
    join
    chk("b2b_cs_low_clks", run, 24);
    chk("b2b_rsp_count", rsp_cyc.size() - base, 3);
    if (rsp_cyc.size() - base == 3) begin
      chk("b2b_rsp_gap1", rsp_cyc[base+1] - rsp_cyc[base], 8);
      chk("b2b_rsp_gap2", rsp_cyc[base+2] - rsp_cyc[base+1], 8);
    end

    // RDY held low for two t0s on a read
    extbus_d_in = 8'h3C;
    base = rsp_cyc.size();
    fork
      begin
        extbus_rdy = 1'b0;
        wait_edge(1'b1, c);
        issue_cmd(1'b0, REG_ADDR_LO, 8'h00, 8'h3C);
        repeat (3) wait_edge(1'b0, c);
        extbus_rdy = 1'b1;
      end
      count_cs_low(run);
    join
`ifdef EXTBUS_MASTER_RDY_EN
    chk("rdy_cs_low_clks", run, 24);
`else
    chk("rdy_cs_low_clks", run, 8);
`endif
    chk("rdy_rsp_count", rsp_cyc.size() - base, 1);
    chk("sb_drained", exp_q.size(), 0);

    // reset in phase 2 of a write with a second command pending
    wait_edge(1'b1, c);
    issue_cmd(1'b1, REG_DATA, 8'h96, 8'h00);
    wait_edge(1'b0, c);
    tick();
    issue_cmd(1'b1, REG_ADDR_LO, 8'h11, 8'h00);
    wait_edge(1'b1, c);
    chk("rst_pre_write_bus", {extbus_cs_n, extbus_d_oe, extbus_d_out, cmd_ready},
        {1'b0, 1'b1, 8'h96, 1'b0});
    tick();
    #2;
    extbus_reset = 1'b1;
    #1;
    chk("rst_mid_outputs", out_vec(), RST_VEC);
    exp_q.delete();
    tick();
    extbus_reset = 1'b0;
    chk("rst_release_ready", {cmd_ready, extbus_phy2}, 2'b10);
    base = rsp_cyc.size();
    wait_edge(1'b1, c);
    chk("rst_first_rise_clks", c, 4);
    run = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (extbus_cs_n === 1'b0) run++;
    end
    chk("rst_no_cycle", run, 0);
    chk("rst_no_rsp", rsp_cyc.size() - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
